// File: rtl/pong_ctrl_axil_slave.sv
// AXI4-Lite slave exposing four 32-bit control registers to the pong image generator.
// Optional build macro PONG_AXIL_SLVERR_EN: unaligned accesses answer SLVERR and are discarded.
module pong_ctrl_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
  output logic [3:0]                      reg_wr_pulse
);

  localparam int NB = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                          run_q;
  logic                          aw_held_q, aw_held_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                          w_held_q, w_held_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [NB-1:0]                 w_strb_q, w_strb_d;
  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic                          ar_held_q, ar_held_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic                          rvalid_q, rvalid_d;
  logic [1:0]                    rresp_q, rresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] slv_q [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] slv_d [4];
  logic [3:0]                    pulse_q, pulse_d;

  logic                          aw_hs, w_hs, ar_hs, commit;
  logic                          wr_err, rd_err;
  logic [1:0]                    wr_idx, rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_merged;
  logic                          unused_ok;

  // run_q keeps the ready outputs low until the first edge after reset release
  assign s00_axi_awready = run_q && !aw_held_q && !bvalid_q;
  assign s00_axi_wready  = run_q && !w_held_q  && !bvalid_q;
  assign s00_axi_arready = run_q && !ar_held_q && !rvalid_q;

  assign aw_hs  = s00_axi_awvalid && s00_axi_awready;
  assign w_hs   = s00_axi_wvalid  && s00_axi_wready;
  assign ar_hs  = s00_axi_arvalid && s00_axi_arready;
  assign commit = aw_held_q && w_held_q && !bvalid_q;

  assign wr_idx = aw_addr_q[3:2];
  assign rd_idx = ar_addr_q[3:2];

`ifdef PONG_AXIL_SLVERR_EN
  assign wr_err = |aw_addr_q[1:0];
  assign rd_err = |ar_addr_q[1:0];
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, aw_addr_q, ar_addr_q};

  always_comb begin
    wr_merged = slv_q[wr_idx];
    for (int unsigned i = 0; i < NB; i++) begin
      if (w_strb_q[i]) wr_merged[8*i +: 8] = w_data_q[8*i +: 8];
    end
  end

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    ar_held_d = ar_held_q;
    ar_addr_d = ar_addr_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    slv_d     = slv_q;
    pulse_d   = '0;

    if (bvalid_q && s00_axi_bready) bvalid_d = 1'b0;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = s00_axi_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s00_axi_wdata;
      w_strb_d = s00_axi_wstrb;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wr_err) begin
        bresp_d = RESP_SLVERR;
      end else begin
        bresp_d         = RESP_OKAY;
        slv_d[wr_idx]   = wr_merged;
        pulse_d[wr_idx] = 1'b1;
      end
    end

    if (rvalid_q && s00_axi_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      ar_held_d = 1'b1;
      ar_addr_d = s00_axi_araddr;
    end
    // slv_q is the pre-commit value, so a same-edge write is not visible here
    if (ar_held_q) begin
      ar_held_d = 1'b0;
      rvalid_d  = 1'b1;
      rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
      rdata_d   = rd_err ? '0 : slv_q[rd_idx];
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      run_q     <= 1'b0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      ar_held_q <= 1'b0;
      ar_addr_q <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      slv_q     <= '{default: '0};
      pulse_q   <= '0;
    end else begin
      run_q     <= 1'b1;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      ar_held_q <= ar_held_d;
      ar_addr_q <= ar_addr_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      slv_q     <= slv_d;
      pulse_q   <= pulse_d;
    end
  end

  assign s00_axi_bvalid = bvalid_q;
  assign s00_axi_bresp  = bresp_q;
  assign s00_axi_rvalid = rvalid_q;
  assign s00_axi_rresp  = rresp_q;
  assign s00_axi_rdata  = rdata_q;
  assign slv_reg0       = slv_q[0];
  assign slv_reg1       = slv_q[1];
  assign slv_reg2       = slv_q[2];
  assign slv_reg3       = slv_q[3];
  assign reg_wr_pulse   = pulse_q;

endmodule

// File: tb/tb_pong_ctrl_axil_slave.sv
// Directed self-checking bench for pong_ctrl_axil_slave; honours PONG_AXIL_SLVERR_EN when defined.
module tb_pong_ctrl_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  pulse;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pong_ctrl_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .slv_reg0(reg0), .slv_reg1(reg1), .slv_reg2(reg2), .slv_reg3(reg3), .reg_wr_pulse(pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int bwait, output logic [1:0] resp, output logic [3:0] pls);
    int  n;
    logic aw_go, w_go, held_ok;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(negedge clk);
      n++;
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid = 1'b0;
    end
    chk("wr_hs_in_time", 32'(n < 20), 32'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("wr_bvalid_rise", 32'(bvalid), 32'd1);
    resp = bresp;
    pls  = pulse;
    held_ok = 1'b1;
    for (int i = 0; i < bwait; i++) begin
      @(negedge clk);
      if (!(bvalid === 1'b1 && awready === 1'b0 && wready === 1'b0 && bresp === resp)) held_ok = 1'b0;
    end
    if (bwait > 0) chk("wr_bvalid_held", 32'(held_ok), 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("wr_bvalid_clear", 32'(bvalid), 32'd0);
    chk("wr_pulse_clear", 32'(pulse), 32'd0);
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    int  n;
    logic go;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      go = arready;
      @(negedge clk);
      n++;
      if (go) arvalid = 1'b0;
    end
    chk("rd_hs_in_time", 32'(n < 20), 32'd1);
    arvalid = 1'b0;
    chk("rd_rvalid_latency", 32'(rvalid), 32'd0);
    @(negedge clk);
    chk("rd_rvalid_rise", 32'(rvalid), 32'd1);
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rd_rvalid_clear", 32'(rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [3:0]  pls;
    logic [31:0] d;
    logic [31:0] wr_data [4];
    logic [3:0]  wr_pulse [4];
    wr_data  = '{32'h1, 32'h2, 32'h3, 32'h4};
    wr_pulse = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Reset state and ready rise
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_awready_low", 32'(awready), 32'd0);
    @(negedge clk);
    chk("rel_awready_up", 32'(awready), 32'd1);
    chk("rel_wready_up", 32'(wready), 32'd1);
    chk("rel_arready_up", 32'(arready), 32'd1);

    // Basic write then read-back of all four registers
    for (int i = 0; i < 4; i++) begin
      do_write(4'(4 * i), wr_data[i], 4'hF, 0, resp, pls);
      chk("basic_bresp", 32'(resp), 32'd0);
      chk("basic_pulse", 32'(pls), 32'(wr_pulse[i]));
    end
    chk("basic_reg0", reg0, 32'h1);
    chk("basic_reg1", reg1, 32'h2);
    chk("basic_reg2", reg2, 32'h3);
    chk("basic_reg3", reg3, 32'h4);
    for (int i = 0; i < 4; i++) begin
      do_read(4'(4 * i), d, resp);
      chk("basic_rdata", d, wr_data[i]);
      chk("basic_rresp", 32'(resp), 32'd0);
    end

    // W three cycles ahead of AW
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("wfirst_wready_low", 32'(wready), 32'd0);
    chk("wfirst_no_bvalid", 32'(bvalid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    awaddr = 4'h8; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("wfirst_reg2_old", reg2, 32'h3);
    chk("wfirst_bvalid_n", 32'(bvalid), 32'd0);
    @(negedge clk);
    chk("wfirst_reg2_new", reg2, 32'hDEADBEEF);
    chk("wfirst_bvalid", 32'(bvalid), 32'd1);
    chk("wfirst_pulse", 32'(pulse), 32'b0100);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("wfirst_bvalid_clr", 32'(bvalid), 32'd0);
    @(negedge clk);
    chk("wfirst_single_b", 32'(bvalid), 32'd0);

    // Byte strobes
    do_write(4'h4, 32'hFFFFFFFF, 4'hF, 0, resp, pls);
    do_write(4'h4, 32'h12345678, 4'b0101, 0, resp, pls);
    chk("strb_reg1", reg1, 32'hFF34FF78);

    // Zero strobe still pulses, no change
    do_write(4'hC, 32'hCAFEF00D, 4'h0, 0, resp, pls);
    chk("strb0_bresp", 32'(resp), 32'd0);
    chk("strb0_pulse", 32'(pls), 32'b1000);
    chk("strb0_reg3", reg3, 32'h4);

    // Backpressured write response
    do_write(4'h4, 32'h2, 4'hF, 10, resp, pls);
    chk("bp_reg1", reg1, 32'h2);
    chk("bp_awready_back", 32'(awready), 32'd1);

    // Read and write commit to the same register on the same edge
    awaddr = 4'h4; wdata = 32'hAA; wstrb = 4'hF; araddr = 4'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    chk("rw_rvalid", 32'(rvalid), 32'd1);
    chk("rw_rdata_old", rdata, 32'h2);
    chk("rw_bvalid", 32'(bvalid), 32'd1);
    chk("rw_reg1_new", reg1, 32'hAA);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    do_read(4'h4, d, resp);
    chk("rw_rdata_new", d, 32'hAA);

    // Unaligned address
    do_write(4'h2, 32'h5, 4'hF, 0, resp, pls);
    do_read(4'h2, d, resp);
`ifdef PONG_AXIL_SLVERR_EN
    chk("unal_rdata", d, 32'h0);
    chk("unal_rresp", 32'(resp), 32'd2);
    chk("unal_reg0", reg0, 32'h1);
    chk("unal_pulse", 32'(pls), 32'd0);
`else
    chk("unal_rdata", d, 32'h5);
    chk("unal_rresp", 32'(resp), 32'd0);
    chk("unal_reg0", reg0, 32'h5);
    chk("unal_pulse", 32'(pls), 32'b0001);
`endif
    do_write(4'h2, 32'h6, 4'hF, 0, resp, pls);
`ifdef PONG_AXIL_SLVERR_EN
    chk("unal_bresp", 32'(resp), 32'd2);
`else
    chk("unal_bresp", 32'(resp), 32'd0);
`endif

    // Reset while both responses are pending
    awaddr = 4'h4; wdata = 32'h77; wstrb = 4'hF; araddr = 4'h8;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    chk("mid_bvalid_pre", 32'(bvalid), 32'd1);
    chk("mid_rvalid_pre", 32'(rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_bvalid", 32'(bvalid), 32'd0);
    chk("mid_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rdata", rdata, 32'd0);
    chk("mid_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
    chk("mid_pulse", 32'(pulse), 32'd0);
    chk("mid_readys", 32'({awready, wready, arready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_bvalid", 32'(bvalid), 32'd0);
    chk("post_rvalid", 32'(rvalid), 32'd0);
    chk("post_reg1", reg1, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
